// File: rtl/hazard_sched.sv
// Pipeline hazard scheduler: load-use stalls, taken-branch flushes and memory-wait
// freezes, with saturating stall and flush performance counters.
module hazard_sched #(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_regwen,
  input  logic             br_taken,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             back_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    MWAIT  = 2'd2
  } state_t;

  localparam logic [1:0] LCNT_INIT = 2'(LOAD_LAT - 1);

  state_t           state_reg, state_next;
  logic [1:0]       lcnt_reg, lcnt_next;
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;
  logic             hazard;
  logic             run_eval;
  logic             pc_en_c, ifid_en_c, ifid_flush_c, idex_flush_c, back_en_c;

  assign hazard = id_valid & ex_is_load & ex_regwen & (ex_rd != 5'd0) &
                  ((ex_rd == id_rs1) | (id_use_rs2 & (ex_rd == id_rs2)));

  always_comb begin
    state_next   = state_reg;
    lcnt_next    = lcnt_reg;
    run_eval     = 1'b0;
    pc_en_c      = 1'b0;
    ifid_en_c    = 1'b0;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;
    back_en_c    = 1'b0;

    case (state_reg)
      RUN: run_eval = 1'b1;
      LSTALL: begin
        // A memory freeze holds the remaining stall count untouched.
        if (!mem_busy) begin
          idex_flush_c = 1'b1;
          back_en_c    = 1'b1;
          lcnt_next    = lcnt_reg - 2'd1;
          if (lcnt_reg == 2'd1) state_next = RUN;
        end
      end
      MWAIT: begin
        // Release cycle behaves exactly like RUN, including a held branch.
        if (!mem_busy) run_eval = 1'b1;
      end
      default: state_next = RUN;
    endcase

    if (run_eval) begin
      state_next = RUN;
      if (mem_busy) begin
        state_next = MWAIT;
      end else if (br_taken) begin
        pc_en_c      = 1'b1;
        ifid_en_c    = 1'b1;
        ifid_flush_c = 1'b1;
        idex_flush_c = 1'b1;
        back_en_c    = 1'b1;
      end else if (hazard) begin
        idex_flush_c = 1'b1;
        back_en_c    = 1'b1;
        if (LOAD_LAT > 1) begin
          state_next = LSTALL;
          lcnt_next  = LCNT_INIT;
        end
      end else begin
        pc_en_c   = 1'b1;
        ifid_en_c = 1'b1;
        back_en_c = 1'b1;
      end
    end
  end

  // Reset gates every control output so the pipe stays frozen while held.
  assign pc_en      = rst & pc_en_c;
  assign ifid_en    = rst & ifid_en_c;
  assign ifid_flush = rst & ifid_flush_c;
  assign idex_flush = rst & idex_flush_c;
  assign back_en    = rst & back_en_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= RUN;
      lcnt_reg      <= 2'd0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      lcnt_reg  <= lcnt_next;
      if (!pc_en && (stall_cnt_reg != {CNT_W{1'b1}}))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (ifid_flush && (flush_cnt_reg != {CNT_W{1'b1}}))
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign state     = state_reg;
  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_sched.sv
// Scoreboard bench for hazard_sched: LOAD_LAT=1 and 3 instances plus a 2-bit counter
// instance for saturation, all driven with identical stimulus.
module tb_hazard_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_rs2, ex_is_load, ex_regwen, br_taken, mem_busy;
  logic [4:0] id_rs1, id_rs2, ex_rd;

  logic        pc_en1, ifid_en1, ifid_flush1, idex_flush1, back_en1;
  logic [1:0]  state1;
  logic [15:0] stall_cnt1, flush_cnt1;
  logic        pc_en3, ifid_en3, ifid_flush3, idex_flush3, back_en3;
  logic [1:0]  state3;
  logic [15:0] stall_cnt3, flush_cnt3;
  logic        pc_ens, ifid_ens, ifid_flushs, idex_flushs, back_ens;
  logic [1:0]  states;
  logic [1:0]  stall_cnts, flush_cnts;

  always #5 clk = ~clk;

  hazard_sched #(.LOAD_LAT(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_regwen(ex_regwen),
    .br_taken(br_taken), .mem_busy(mem_busy), .pc_en(pc_en1), .ifid_en(ifid_en1),
    .ifid_flush(ifid_flush1), .idex_flush(idex_flush1), .back_en(back_en1), .state(state1),
    .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1));

  hazard_sched #(.LOAD_LAT(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_regwen(ex_regwen),
    .br_taken(br_taken), .mem_busy(mem_busy), .pc_en(pc_en3), .ifid_en(ifid_en3),
    .ifid_flush(ifid_flush3), .idex_flush(idex_flush3), .back_en(back_en3), .state(state3),
    .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3));

  hazard_sched #(.LOAD_LAT(1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_regwen(ex_regwen),
    .br_taken(br_taken), .mem_busy(mem_busy), .pc_en(pc_ens), .ifid_en(ifid_ens),
    .ifid_flush(ifid_flushs), .idex_flush(idex_flushs), .back_en(back_ens), .state(states),
    .stall_cnt(stall_cnts), .flush_cnt(flush_cnts));

  // Control vectors: {pc_en, ifid_en, ifid_flush, idex_flush, back_en}
  localparam logic [4:0] RUNC = 5'b11001;
  localparam logic [4:0] HAZ  = 5'b00011;
  localparam logic [4:0] BR   = 5'b11111;
  localparam logic [4:0] FRZ  = 5'b00000;

  typedef struct {
    int         idx;
    logic [4:0] c1;
    logic [1:0] s1;
    int         st1, fl1;
    logic [4:0] c3;
    logic [1:0] s3;
    int         st3, fl3;
  } txn_t;

  txn_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   step_no = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic step(input logic r, input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u2, input logic [4:0] rd, input logic ld, input logic wen,
                      input logic br, input logic busy,
                      input logic [4:0] c1, input logic [1:0] s1, input int st1, input int fl1,
                      input logic [4:0] c3, input logic [1:0] s3, input int st3, input int fl3);
    txn_t t;
    @(posedge clk);
    #1;
    rst = r; id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs2 = u2;
    ex_rd = rd; ex_is_load = ld; ex_regwen = wen; br_taken = br; mem_busy = busy;
    t.idx = step_no; t.c1 = c1; t.s1 = s1; t.st1 = st1; t.fl1 = fl1;
    t.c3 = c3; t.s3 = s3; t.st3 = st3; t.fl3 = fl3;
    sb.push_back(t);
    $display("step %0d: rst=%0b v=%0b rs1=%0d rs2=%0d use2=%0b rd=%0d ld=%0b br=%0b busy=%0b",
             step_no, r, v, rs1, rs2, u2, rd, ld, br, busy);
    step_no++;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      txn_t t;
      t = sb.pop_front();
      chk($sformatf("s%0d.ctrl_lat1", t.idx),
          {27'd0, pc_en1, ifid_en1, ifid_flush1, idex_flush1, back_en1}, {27'd0, t.c1});
      chk($sformatf("s%0d.state_lat1", t.idx), {30'd0, state1}, {30'd0, t.s1});
      chk($sformatf("s%0d.stall_lat1", t.idx), {16'd0, stall_cnt1}, t.st1);
      chk($sformatf("s%0d.flush_lat1", t.idx), {16'd0, flush_cnt1}, t.fl1);
      chk($sformatf("s%0d.ctrl_lat3", t.idx),
          {27'd0, pc_en3, ifid_en3, ifid_flush3, idex_flush3, back_en3}, {27'd0, t.c3});
      chk($sformatf("s%0d.state_lat3", t.idx), {30'd0, state3}, {30'd0, t.s3});
      chk($sformatf("s%0d.stall_lat3", t.idx), {16'd0, stall_cnt3}, t.st3);
      chk($sformatf("s%0d.flush_lat3", t.idx), {16'd0, flush_cnt3}, t.fl3);
      chk($sformatf("s%0d.stall_sat", t.idx), {30'd0, stall_cnts}, sat3(t.st1));
      chk($sformatf("s%0d.flush_sat", t.idx), {30'd0, flush_cnts}, sat3(t.fl1));
    end
  end

  initial begin
    rst = 1'b0; id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_is_load = 1'b0; ex_regwen = 1'b0; br_taken = 1'b0; mem_busy = 1'b0;

    //    rst v rs1 rs2 u2 rd ld wen br busy | lat1: ctrl st stall flush | lat3: ctrl st stall flush
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  FRZ,  0, 0, 0,  FRZ,  0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  RUNC, 0, 0, 0,  RUNC, 0, 0, 0);
    // load x5 in EX, add x5 in ID
    step(1, 1, 5, 0, 1, 5, 1, 1, 0, 0,  HAZ,  0, 0, 0,  HAZ,  0, 0, 0);
    step(1, 1, 5, 0, 1, 0, 0, 0, 0, 0,  RUNC, 0, 1, 0,  HAZ,  1, 1, 0);
    step(1, 1, 5, 0, 1, 0, 0, 0, 0, 0,  RUNC, 0, 1, 0,  HAZ,  1, 2, 0);
    step(1, 1, 5, 0, 1, 0, 0, 0, 0, 0,  RUNC, 0, 1, 0,  RUNC, 0, 3, 0);
    // taken branch beats a simultaneous hazard
    step(1, 1, 5, 0, 1, 5, 1, 1, 1, 0,  BR,   0, 1, 0,  BR,   0, 3, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  RUNC, 0, 1, 1,  RUNC, 0, 3, 1);
    // x0 destination, then rs2 match ignored without id_use_rs2
    step(1, 1, 0, 0, 1, 0, 1, 1, 0, 0,  RUNC, 0, 1, 1,  RUNC, 0, 3, 1);
    step(1, 1, 3, 7, 0, 7, 1, 1, 0, 0,  RUNC, 0, 1, 1,  RUNC, 0, 3, 1);
    // rs2 hazard, then mem_busy x4 with LSTALL counter at 1
    step(1, 1, 3, 7, 1, 7, 1, 1, 0, 0,  HAZ,  0, 1, 1,  HAZ,  0, 3, 1);
    step(1, 1, 3, 7, 1, 0, 0, 0, 0, 0,  RUNC, 0, 2, 1,  HAZ,  1, 4, 1);
    step(1, 1, 3, 7, 1, 0, 0, 0, 0, 1,  FRZ,  0, 2, 1,  FRZ,  1, 5, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1,  FRZ,  2, 3, 1,  FRZ,  1, 6, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1,  FRZ,  2, 4, 1,  FRZ,  1, 7, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1,  FRZ,  2, 5, 1,  FRZ,  1, 8, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  RUNC, 2, 6, 1,  HAZ,  1, 9, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  RUNC, 0, 6, 1,  RUNC, 0, 10, 1);
    // branch held through a freeze, acted on once at release
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1,  FRZ,  0, 6, 1,  FRZ,  0, 10, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0,  BR,   2, 7, 1,  BR,   2, 11, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  RUNC, 0, 7, 2,  RUNC, 0, 11, 2);
    // reset pulsed during MWAIT
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1,  FRZ,  0, 7, 2,  FRZ,  0, 11, 2);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1,  FRZ,  2, 8, 2,  FRZ,  2, 12, 2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  FRZ,  0, 0, 0,  FRZ,  0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  RUNC, 0, 0, 0,  RUNC, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  RUNC, 0, 0, 0,  RUNC, 0, 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_sched.md
HAZARD_SCHED -- requirements
Module: hazard_sched

Parameters
REQ-001 The block SHALL have parameter LOAD_LAT, default 1, legal range 1..3: total load-use stall cycles per hazard.
REQ-002 The block SHALL have parameter CNT_W, default 16: width of the performance counters.

Interface
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 id_valid  input  1  decode stage holds a real instruction.
REQ-007 id_rs1  input  5  decode-stage rs1 index.
REQ-008 id_rs2  input  5  decode-stage rs2 index.
REQ-009 id_use_rs2  input  1  decode instruction reads rs2 (R, S and B type).
REQ-010 ex_rd  input  5  execute-stage rd.
REQ-011 ex_is_load  input  1  execute-stage instruction is a load.
REQ-012 ex_regwen  input  1  execute-stage RegWEn.
REQ-013 br_taken  input  1  execute stage resolved a taken branch or jump.
REQ-014 mem_busy  input  1  LSU/IO access is not complete this cycle.
REQ-015 pc_en  output  1  PC register update enable.
REQ-016 ifid_en  output  1  IF/ID pipe register enable.
REQ-017 ifid_flush  output  1  IF/ID loads NOP.
REQ-018 idex_flush  output  1  ID/EX loads bubble (all write enables 0).
REQ-019 back_en  output  1  EX/MEM and MEM/WB pipe register enable.
REQ-020 state  output  2  FSM state: 0 RUN, 1 LSTALL, 2 MWAIT.
REQ-021 stall_cnt  output  CNT_W  stall cycles counted.
REQ-022 flush_cnt  output  CNT_W  taken-branch flushes counted.

Function
REQ-023 Control outputs SHALL be combinational from the current state and inputs; state and counters SHALL be registered.
REQ-024 The hazard term SHALL be id_valid & ex_is_load & ex_regwen & (ex_rd != 0) & ((ex_rd == id_rs1) | (id_use_rs2 & (ex_rd == id_rs2))).
REQ-025 Outputs in RUN, priority order:
- mem_busy: all enables 0, no flush; next state MWAIT.
- else br_taken: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1, back_en=1; next state RUN.
- else hazard: pc_en=0, ifid_en=0, idex_flush=1, back_en=1; next state LSTALL if LOAD_LAT>1, else RUN.
- else: all enables 1, no flush.
REQ-026 On entry to LSTALL the counter SHALL load LOAD_LAT-1.
REQ-027 In LSTALL, outputs SHALL equal the hazard case. The counter SHALL decrement each cycle. The FSM SHALL return to RUN in the cycle the counter equals 1.
REQ-028 In LSTALL, mem_busy SHALL force all enables to 0 with no flush and SHALL hold the counter.
REQ-029 In MWAIT, all enables SHALL be 0 with no flush while mem_busy=1. On the first cycle with mem_busy=0, the FSM SHALL move to RUN and the outputs SHALL be those of RUN for that cycle.
REQ-030 br_taken asserted during a freeze SHALL be held by the frozen EX stage. It SHALL be acted on once when the freeze releases.
REQ-031 stall_cnt SHALL increment in every cycle where pc_en=0. flush_cnt SHALL increment in every cycle where ifid_flush=1. Both counters SHALL saturate at all-ones.
REQ-032 An ex_rd of x0 SHALL never cause a stall.
REQ-033 State encoding 3 SHALL be unreachable. If it is ever reached, the next state SHALL be RUN.

Reset
REQ-034 On rst=0 the FSM SHALL asynchronously enter RUN, with the LSTALL counter and both performance counters at 0.
REQ-035 While rst=0, pc_en, ifid_en and back_en SHALL be 0, and ifid_flush and idex_flush SHALL be 0.
REQ-036 Reset asserted mid-stall or mid-wait SHALL abort to RUN with no residual stall after release.

Verification
REQ-037 Load x5 in EX, add reading x5 in ID, LOAD_LAT=1 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1; next cycle all enables 1; stall_cnt=1.
REQ-038 Same stimulus with LOAD_LAT=3 -> three stall cycles; state sequence RUN, LSTALL, LSTALL, RUN; stall_cnt=3.
REQ-039 br_taken=1 with a simultaneous hazard -> ifid_flush=1, idex_flush=1, pc_en=1, no stall; flush_cnt=1.
REQ-040 mem_busy high for 4 cycles during LSTALL with counter=1 -> all enables 0 for 4 cycles, counter held; one LSTALL cycle remains after release.
REQ-041 Load to x0 with ID reading x0 -> no stall. Load x7 with id_use_rs2=0 and id_rs2=7 -> no stall.
REQ-042 rst pulsed low during MWAIT -> state=0 and counters 0 immediately; after release with mem_busy=0, all enables 1 on the first clock.
